// File: rtl/fp_add_sub_pipe.sv
// Three-stage pipelined floating-point adder/subtractor with runtime add/sub select,
// stall enable and overflow/invalid flags. Denormals are flushed to signed zero.
module fp_add_sub_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    localparam int unsigned W = 1 + EXP_W + MAN_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clk_en,
    input  logic         in_valid,
    input  logic         sub,
    input  logic [W-1:0] dataa,
    input  logic [W-1:0] datab,
    output logic         out_valid,
    output logic [W-1:0] result,
    output logic         overflow,
    output logic         invalid
);

    localparam int unsigned SW  = MAN_W + 5;
    localparam int unsigned LZW = $clog2(MAN_W + 5);
    localparam int unsigned XW  = ((EXP_W > LZW) ? EXP_W : LZW) + 2;

    function automatic logic [LZW-1:0] lzc(input logic [MAN_W+3:0] v);
        logic [LZW-1:0] n;
        logic           hit;
        n   = '0;
        hit = 1'b0;
        for (int i = MAN_W + 3; i >= 0; i--) begin
            if (!hit && !v[i]) n = n + 1'b1;
            else hit = 1'b1;
        end
        return n;
    endfunction

    // ---------------- Stage 1: unpack / swap ----------------
    logic             a_sign, b_sign;
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_frac, b_frac;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [MAN_W:0]   a_man, b_man;
    logic             swap;

    assign a_sign = dataa[W-1];
    assign b_sign = datab[W-1] ^ sub;
    assign a_exp  = dataa[W-2 -: EXP_W];
    assign b_exp  = datab[W-2 -: EXP_W];
    assign a_frac = dataa[MAN_W-1:0];
    assign b_frac = datab[MAN_W-1:0];
    assign a_zero = ~|a_exp;
    assign b_zero = ~|b_exp;
    assign a_nan  = (&a_exp) & (|a_frac);
    assign b_nan  = (&b_exp) & (|b_frac);
    assign a_inf  = (&a_exp) & ~(|a_frac);
    assign b_inf  = (&b_exp) & ~(|b_frac);
    assign a_man  = a_zero ? '0 : {1'b1, a_frac};
    assign b_man  = b_zero ? '0 : {1'b1, b_frac};
    assign swap   = {b_exp, b_frac} > {a_exp, a_frac};

    logic             s1_valid_q, s1_sign_l_q, s1_sign_s_q;
    logic [EXP_W-1:0] s1_exp_q, s1_shift_q;
    logic [MAN_W:0]   s1_man_l_q, s1_man_s_q;
    logic             s1_nan_q, s1_inf_q, s1_inf_sign_q;

    // ---------------- Stage 2: align / add ----------------
    logic [MAN_W+2:0] s_ext, s_shift, s_mask;
    logic [MAN_W+3:0] aligned;
    logic [SW-1:0]    big_ext, sum_d;

    always_comb begin
        s_ext   = {s1_man_s_q, 2'b00};
        s_shift = s_ext >> s1_shift_q;
        // Bits pushed past the round position collapse into sticky; huge shifts leave only sticky.
        s_mask  = ~({(MAN_W + 3){1'b1}} << s1_shift_q);
        aligned = {s_shift, |(s_ext & s_mask)};
        big_ext = {1'b0, s1_man_l_q, 3'b000};
        if (s1_sign_l_q == s1_sign_s_q) sum_d = big_ext + {1'b0, aligned};
        else                            sum_d = big_ext - {1'b0, aligned};
    end

    logic             s2_valid_q, s2_sign_q, s2_zero_sign_q;
    logic [EXP_W-1:0] s2_exp_q;
    logic [SW-1:0]    s2_sum_q;
    logic             s2_nan_q, s2_inf_q, s2_inf_sign_q;

    // ---------------- Stage 3: normalise / round / pack ----------------
    logic [LZW-1:0]   lz;
    logic [MAN_W+3:0] norm;
    logic [XW-1:0]    exp_n, exp_r;
    logic [MAN_W:0]   mant;
    logic [MAN_W+1:0] mant_r;
    logic             round_up;
    logic [MAN_W-1:0] frac_r;
    logic [W-1:0]     result_d;
    logic             overflow_d, invalid_d;

    always_comb begin
        lz = lzc(s2_sum_q[MAN_W+3:0]);
        if (s2_sum_q[MAN_W+4]) begin
            norm  = {s2_sum_q[MAN_W+4:2], s2_sum_q[1] | s2_sum_q[0]};
            exp_n = XW'(s2_exp_q) + XW'(1);
        end else begin
            norm  = s2_sum_q[MAN_W+3:0] << lz;
            exp_n = XW'(s2_exp_q) - XW'(lz);
        end
        mant     = norm[MAN_W+3:3];
        round_up = norm[2] & (norm[1] | norm[0] | mant[0]);
        mant_r   = {1'b0, mant} + (MAN_W + 2)'(round_up);
        exp_r    = exp_n + XW'(mant_r[MAN_W+1]);
        frac_r   = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];

        overflow_d = 1'b0;
        invalid_d  = 1'b0;
        if (s2_nan_q) begin
            result_d  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};
            invalid_d = 1'b1;
        end else if (s2_inf_q) begin
            result_d = {s2_inf_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (~|s2_sum_q) begin
            result_d = {s2_zero_sign_q, {(W - 1){1'b0}}};
        end else if (!exp_r[XW-1] && exp_r >= XW'((1 << EXP_W) - 1)) begin
            result_d   = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            overflow_d = 1'b1;
        end else if (exp_r[XW-1] || exp_r == '0) begin
            result_d = {s2_sign_q, {(W - 1){1'b0}}};
        end else begin
            result_d = {s2_sign_q, exp_r[EXP_W-1:0], frac_r};
        end
    end

    // ---------------- Pipeline registers ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_q     <= 1'b0;
            s1_sign_l_q    <= 1'b0;
            s1_sign_s_q    <= 1'b0;
            s1_exp_q       <= '0;
            s1_shift_q     <= '0;
            s1_man_l_q     <= '0;
            s1_man_s_q     <= '0;
            s1_nan_q       <= 1'b0;
            s1_inf_q       <= 1'b0;
            s1_inf_sign_q  <= 1'b0;
            s2_valid_q     <= 1'b0;
            s2_sign_q      <= 1'b0;
            s2_zero_sign_q <= 1'b0;
            s2_exp_q       <= '0;
            s2_sum_q       <= '0;
            s2_nan_q       <= 1'b0;
            s2_inf_q       <= 1'b0;
            s2_inf_sign_q  <= 1'b0;
            out_valid      <= 1'b0;
            result         <= '0;
            overflow       <= 1'b0;
            invalid        <= 1'b0;
        end else if (clk_en) begin
            s1_valid_q     <= in_valid;
            s1_sign_l_q    <= swap ? b_sign : a_sign;
            s1_sign_s_q    <= swap ? a_sign : b_sign;
            s1_exp_q       <= swap ? b_exp : a_exp;
            s1_shift_q     <= swap ? (b_exp - a_exp) : (a_exp - b_exp);
            s1_man_l_q     <= swap ? b_man : a_man;
            s1_man_s_q     <= swap ? a_man : b_man;
            s1_nan_q       <= a_nan | b_nan | (a_inf & b_inf & (a_sign != b_sign));
            s1_inf_q       <= a_inf | b_inf;
            s1_inf_sign_q  <= a_inf ? a_sign : b_sign;
            s2_valid_q     <= s1_valid_q;
            s2_sign_q      <= s1_sign_l_q;
            // A zero sum is negative only when both addends are (signed) negative zeros.
            s2_zero_sign_q <= s1_sign_l_q & s1_sign_s_q;
            s2_exp_q       <= s1_exp_q;
            s2_sum_q       <= sum_d;
            s2_nan_q       <= s1_nan_q;
            s2_inf_q       <= s1_inf_q;
            s2_inf_sign_q  <= s1_inf_sign_q;
            out_valid      <= s2_valid_q;
            result         <= result_d;
            overflow       <= overflow_d & s2_valid_q;
            invalid        <= invalid_d & s2_valid_q;
        end
    end

endmodule

// File: tb/tb_fp_add_sub_pipe.sv
// Directed scoreboard bench for fp_add_sub_pipe: single and half precision instances,
// back-to-back ops, rounding, specials, stall and mid-flight reset.
module tb_fp_add_sub_pipe;

    typedef struct {
        logic [31:0] res;
        logic        ov;
        logic        inv;
        int          edge_no;
    } exp_t;

    logic        clock, reset, clk_en;
    logic        in_valid, sub, h_in_valid, h_sub;
    logic [31:0] dataa, datab, result;
    logic [15:0] h_a, h_b, h_result;
    logic        out_valid, overflow, invalid;
    logic        h_out_valid, h_overflow, h_invalid;

    exp_t        q32[$];
    exp_t        q16[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_edge = 0;
    logic        lv32 = 1'b0, lv16 = 1'b0;
    logic [31:0] lr32 = '0, lr16 = '0;

    fp_add_sub_pipe u_sp (
        .clock    (clock),
        .reset    (reset),
        .clk_en   (clk_en),
        .in_valid (in_valid),
        .sub      (sub),
        .dataa    (dataa),
        .datab    (datab),
        .out_valid(out_valid),
        .result   (result),
        .overflow (overflow),
        .invalid  (invalid)
    );

    fp_add_sub_pipe #(.EXP_W(5), .MAN_W(10)) u_hp (
        .clock    (clock),
        .reset    (reset),
        .clk_en   (clk_en),
        .in_valid (h_in_valid),
        .sub      (h_sub),
        .dataa    (h_a),
        .datab    (h_b),
        .out_valid(h_out_valid),
        .result   (h_result),
        .overflow (h_overflow),
        .invalid  (h_invalid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [31:0] r, input logic ov, input logic inv, input bit push);
        exp_t e;
        dataa = a; datab = b; sub = s; in_valid = 1'b1;
        e.res = r; e.ov = ov; e.inv = inv; e.edge_no = n_edge + 1;
        if (push) q32.push_back(e);
    endtask

    task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic s,
                           input logic [15:0] r, input logic ov, input logic inv);
        exp_t e;
        h_a = a; h_b = b; h_sub = s; h_in_valid = 1'b1;
        e.res = {16'h0, r}; e.ov = ov; e.inv = inv; e.edge_no = n_edge + 1;
        q16.push_back(e);
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        h_in_valid = 1'b0;
    endtask

    task automatic mon32();
        exp_t e;
        if (q32.size() > 0 && q32[0].edge_no + 2 == n_edge) begin
            e = q32.pop_front();
            check("valid32", 32'(out_valid), 32'd1);
            check("result32", result, e.res);
            check("ovf32", 32'(overflow), 32'(e.ov));
            check("inv32", 32'(invalid), 32'(e.inv));
            lv32 = 1'b1; lr32 = e.res;
        end else begin
            check("idle_valid32", 32'(out_valid), 32'd0);
            check("idle_flags32", {30'd0, overflow, invalid}, 32'd0);
            lv32 = 1'b0;
        end
    endtask

    task automatic mon16();
        exp_t e;
        if (q16.size() > 0 && q16[0].edge_no + 2 == n_edge) begin
            e = q16.pop_front();
            check("valid16", 32'(h_out_valid), 32'd1);
            check("result16", {16'h0, h_result}, e.res);
            check("ovf16", 32'(h_overflow), 32'(e.ov));
            check("inv16", 32'(h_invalid), 32'(e.inv));
            lv16 = 1'b1; lr16 = e.res;
        end else begin
            check("idle_valid16", 32'(h_out_valid), 32'd0);
            check("idle_flags16", {30'd0, h_overflow, h_invalid}, 32'd0);
            lv16 = 1'b0;
        end
    endtask

    task automatic reset_outputs_zero(input string tag);
        check({tag, "_v32"}, 32'(out_valid), 32'd0);
        check({tag, "_r32"}, result, 32'd0);
        check({tag, "_f32"}, {30'd0, overflow, invalid}, 32'd0);
        check({tag, "_v16"}, 32'(h_out_valid), 32'd0);
        check({tag, "_r16"}, {16'h0, h_result}, 32'd0);
        lv32 = 1'b0; lv16 = 1'b0;
    endtask

    // One clock: sample outputs 1 time unit after the rising edge.
    task automatic step();
        logic en;
        en = clk_en && !reset;
        @(posedge clock);
        #1;
        if (reset) begin
            reset_outputs_zero("reset");
        end else if (en) begin
            n_edge++;
            mon32();
            mon16();
        end else begin
            check("hold_valid32", 32'(out_valid), 32'(lv32));
            check("hold_valid16", 32'(h_out_valid), 32'(lv16));
            if (lv32) check("hold_result32", result, lr32);
            if (lv16) check("hold_result16", {16'h0, h_result}, lr16);
        end
    endtask

    initial begin
        reset = 1'b1; clk_en = 1'b1;
        in_valid = 1'b0; sub = 1'b0; dataa = '0; datab = '0;
        h_in_valid = 1'b0; h_sub = 1'b0; h_a = '0; h_b = '0;
        step();
        step();
        reset = 1'b0;
        step();

        // Back-to-back stream, with the half-precision instance running alongside.
        issue32(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0, 1);
        issue16(16'h3C00, 16'h4000, 1'b0, 16'h4200, 1'b0, 1'b0);
        step();
        issue32(32'h43A60000, 32'h41B00000, 1'b1, 32'h439B0000, 1'b0, 1'b0, 1);
        issue16(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 1'b1, 1'b0);
        step();
        issue32(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1);
        issue16(16'h3C00, 16'h3C00, 1'b1, 16'h0000, 1'b0, 1'b0);
        step();
        h_in_valid = 1'b0;
        issue32(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 1'b0, 1'b0, 1);
        step();
        issue32(32'h3F800000, 32'h34000000, 1'b0, 32'h3F800001, 1'b0, 1'b0, 1);
        step();
        issue32(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0, 1);
        step();
        issue32(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0, 1'b1, 1);
        step();
        idle();  // bubble
        step();
        issue32(32'h00000001, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1);
        step();
        issue32(32'h40400000, 32'h40400000, 1'b1, 32'h00000000, 1'b0, 1'b0, 1);
        step();
        issue32(32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 1'b0, 1'b0, 1);
        step();
        issue32(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b0, 1);
        step();
        issue32(32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1);
        step();
        issue32(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b1, 1);
        step();
        issue32(32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 1'b0, 1'b0, 1);
        step();
        issue32(32'hFF800000, 32'hFF800000, 1'b0, 32'hFF800000, 1'b0, 1'b0, 1);
        step();
        issue32(32'h3F800000, 32'h30800000, 1'b1, 32'h3F800000, 1'b0, 1'b0, 1);
        step();
        issue32(32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 1'b0, 1'b0, 1);
        step();
        issue32(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0, 1'b0, 1);
        step();
        issue32(32'h00800000, 32'h00400000, 1'b1, 32'h00800000, 1'b0, 1'b0, 1);
        step();
        issue32(32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 1'b0, 1'b0, 1);
        step();
        idle();
        for (int i = 0; i < 4; i++) step();

        // Stall right after issue: result still needs three enabled edges.
        issue32(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0, 1);
        step();
        idle();
        clk_en = 1'b0;
        for (int i = 0; i < 5; i++) step();
        clk_en = 1'b1;
        step();
        step();
        step();

        // Stall while a result is presented: it must hold.
        issue32(32'h43A60000, 32'h41B00000, 1'b1, 32'h439B0000, 1'b0, 1'b0, 1);
        step();
        idle();
        step();
        step();
        clk_en = 1'b0;
        for (int i = 0; i < 3; i++) step();
        clk_en = 1'b1;
        step();

        // Reset mid-flight: first op emitted, the two behind it are discarded.
        issue32(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0, 1);
        step();
        issue32(32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 1'b0, 1'b0, 0);
        step();
        issue32(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 1'b0, 1'b0, 0);
        step();
        idle();
        #2;
        reset = 1'b1;
        #1;
        reset_outputs_zero("async_reset");
        step();
        #2;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) step();

        check("drain32", 32'(q32.size()), 32'd0);
        check("drain16", 32'(q16.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
